// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   loader_state_t  : FSM states of the loader
//   BYTES_PER_WORD  : host bytes packed into one instruction word
//   BYTE_CNT_W      : width of the per-word byte counter
//   accepts_bytes() : states in which the host link is allowed to deliver a byte
//   can_start()     : states in which load_start is honoured
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == HDR) || (s == LOAD) || (s == CSUM);
  endfunction

  function automatic logic can_start(input loader_state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERROR);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer.
//   clock, reset : clock and asynchronous active-low reset
//   clear        : drop any partial word and restart at byte 0
//   byte_en      : byte_in is consumed this cycle
//   byte_in      : incoming byte (first byte of a word lands in [7:0])
//   word         : the word as it stands including byte_in (valid with word_full)
//   word_full    : byte_in is the last byte of a word; word is complete this cycle
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full
);

  logic [BYTE_CNT_W-1:0]   byte_cnt;
  // Bytes received so far in the current word; the newest sits at the top so that
  // after the last byte the first one has been shifted down to [7:0].
  logic [DATA_WIDTH-9:0]   shift_q;

  // The completed word is presented in the same cycle as its last byte so the
  // caller can register it without an extra cycle of latency.
  assign word      = {byte_in, shift_q};
  assign word_full = byte_en && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  // NOTE: registers are updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 1'b1;  // wraps to 0 after the last byte of a word
      shift_q  <= word[DATA_WIDTH-1:8];
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory write port.
// Receives a framed byte stream (4-byte LE word count N, N LE payload words, one
// XOR checksum byte), writes the words to consecutive addresses and releases the
// core only when the checksum matches.
//   clock, reset  : clock and asynchronous active-low reset
//   load_start    : begin a new load (honoured in IDLE/DONE/ERROR)
//   rx_valid/rx_data/rx_ready : host byte stream, valid/ready handshake
//   mem_wr_en/mem_wr_addr/mem_wr_data : instruction memory write port
//   core_run      : core may fetch/execute
//   load_done     : last load completed with a good checksum
//   load_error    : last load failed (oversize header or bad checksum)
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  core_run,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [DATA_WIDTH-1:0] DEPTH = DATA_WIDTH'(1) << ADDR_WIDTH;

  loader_state_t state, next_state;

  logic                  byte_fire;
  logic                  start_go;
  logic                  pk_en;
  logic [DATA_WIDTH-1:0] pk_word;
  logic                  pk_full;
  // One bit wider than an address so N == DEPTH and the post-increment index fit.
  logic [ADDR_WIDTH:0]   last_idx;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [7:0]            xor_acc;

  assign byte_fire = rx_valid && rx_ready;
  assign start_go  = load_start && can_start(state);
  // The header count and the payload words share the same little-endian packing.
  assign pk_en     = byte_fire && ((state == HDR) || (state == LOAD));

  imem_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_go),
    .byte_en   (pk_en),
    .byte_in   (rx_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    // NOTE: default assignment first so every path drives next_state and no latch
    // is inferred.
    next_state = state;
    unique case (state)
      IDLE, DONE, ERROR: if (load_start) next_state = HDR;
      HDR: begin
        if (pk_full) begin
          // The full 32-bit count is compared, so a set upper byte is oversize too.
          if (pk_word > DEPTH)     next_state = ERROR;
          else if (pk_word == '0)  next_state = CSUM;
          else                     next_state = LOAD;
        end
      end
      LOAD:  if (pk_full) next_state = WRITE;
      WRITE: next_state = (word_idx == last_idx) ? CSUM : LOAD;
      CSUM:  if (byte_fire) next_state = (rx_data == xor_acc) ? DONE : ERROR;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- state outputs
  always_comb begin
    rx_ready   = accepts_bytes(state);
    mem_wr_en  = (state == WRITE);
    core_run   = (state == DONE);
    load_done  = (state == DONE);
    load_error = (state == ERROR);
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_idx    <= '0;
      word_idx    <= '0;
      xor_acc     <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      if (start_go) begin
        last_idx <= '0;
        word_idx <= '0;
        xor_acc  <= '0;
      end
      // Value is only consulted when N > 0, so the N == 0 underflow is harmless.
      if ((state == HDR) && pk_full) last_idx <= pk_word[ADDR_WIDTH:0] - 1'b1;
      if ((state == LOAD) && byte_fire) xor_acc <= xor_acc ^ rx_data;
      // Captured on the last byte so the write strobe follows one cycle later.
      if ((state == LOAD) && pk_full) begin
        mem_wr_addr <= word_idx[ADDR_WIDTH-1:0];
        mem_wr_data <= pk_word;
      end
      if (state == WRITE) word_idx <= word_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader.
// The reference model works at frame level: from the payload words and the header
// count it derives which writes must appear, when the handshake must stall, and
// whether the load must end in DONE or ERROR. A single compare process checks every
// DUT output against that model on each falling edge.
module tb_imem_boot_loader;

  localparam int DEPTH = 4096;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_wr_en;
  logic [11:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        core_run;
  logic        load_done;
  logic        load_error;

  imem_boot_loader #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (12)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load_start  (load_start),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .core_run    (core_run),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------- model state
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_writes = 0;
  bit          chk_on = 1'b0;
  bit          exp_busy = 1'b0;   // a frame is in progress (HDR/LOAD/WRITE/CSUM)
  bit          exp_done = 1'b0;
  bit          exp_error = 1'b0;
  bit          write_due = 1'b0;  // previous edge completed a payload word
  wr_t         exp_wq[$];
  logic [31:0] pay[$];            // payload words of the frame under test
  logic [31:0] mem_img [0:DEPTH-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] frame_xor();
    logic [7:0] x = 8'h00;
    foreach (pay[i]) for (int j = 0; j < 4; j++) x ^= pay[i][8*j +: 8];
    return x;
  endfunction

  // ---------------------------------------------------------------- compare process
  always @(negedge clock) begin
    if (chk_on) begin
      check("rx_ready",   rx_ready,   exp_busy && !write_due);
      check("mem_wr_en",  mem_wr_en,  write_due);
      check("core_run",   core_run,   exp_done);
      check("load_done",  load_done,  exp_done);
      check("load_error", load_error, exp_error);
      if (mem_wr_en) begin
        n_writes++;
        mem_img[mem_wr_addr] = mem_wr_data;
        if (exp_wq.size() > 0) begin
          wr_t w;
          w = exp_wq.pop_front();
          check("mem_wr_addr", mem_wr_addr, w.addr);
          check("mem_wr_data", mem_wr_data, w.data);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic start_load();
    @(negedge clock);
    load_start = 1'b1;
    @(posedge clock);
    #1;
    load_start = 1'b0;
    exp_done   = 1'b0;
    exp_error  = 1'b0;
    exp_busy   = 1'b1;
  endtask

  // Offers one byte until the DUT takes it; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
    bit taken = 1'b0;
    int cycles = 0;
    while (!taken) begin
      @(negedge clock);
      rx_data    = b;
      rx_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      load_start = with_start;
      #1;
      taken = rx_valid && rx_ready;
      @(posedge clock);
      #1;
      load_start = 1'b0;
      write_due  = 1'b0;  // any WRITE cycle has ended at this edge
      cycles++;
      if (!taken && cycles > 64) begin
        n_vec++;
        n_bad++;
        $display("FAIL byte_accept_timeout: byte 0x%0h not taken after %0d cycles", b, cycles);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
      end
    end
  endtask

  // Sends a frame with header count n and payload pay[]; the model outcome follows
  // from the frame rules. stop_after >= 0 truncates the stream after that many bytes.
  task automatic run_frame(input logic [31:0] n, input bit bad_csum, input bit gaps,
                           input int stop_after, input int start_at);
    logic [7:0] bytes[$];
    logic [7:0] good;
    int         total;
    int         nn;
    good = frame_xor();
    for (int i = 0; i < 4; i++) bytes.push_back(n[8*i +: 8]);
    if (n <= DEPTH) begin
      foreach (pay[i]) for (int j = 0; j < 4; j++) bytes.push_back(pay[i][8*j +: 8]);
      bytes.push_back(bad_csum ? (good ^ 8'h01) : good);
    end
    nn    = (n <= DEPTH) ? int'(n) : 0;
    total = (stop_after >= 0 && stop_after < bytes.size()) ? stop_after : bytes.size();
    start_load();
    for (int k = 0; k < total; k++) begin
      send_byte(bytes[k], gaps, k == start_at);
      if (k == 3) begin
        if (n > DEPTH) begin
          exp_busy  = 1'b0;
          exp_error = 1'b1;
        end
      end else if (k >= 4 && k < 4 + 4 * nn) begin
        if ((k - 4) % 4 == 3) begin
          write_due = 1'b1;
          exp_wq.push_back('{addr: 12'((k - 4) / 4), data: pay[(k - 4) / 4]});
        end
      end else if (k == 4 + 4 * nn) begin
        exp_busy = 1'b0;
        if (bytes[k] == good) exp_done  = 1'b1;
        else                  exp_error = 1'b1;
      end
    end
    @(negedge clock);
    rx_valid = 1'b0;
    check("write_queue_drained", exp_wq.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"},   rx_ready,    0);
    check({tag, "_mem_wr_en"},  mem_wr_en,   0);
    check({tag, "_mem_wr_addr"}, mem_wr_addr, 0);
    check({tag, "_mem_wr_data"}, mem_wr_data, 0);
    check({tag, "_core_run"},   core_run,    0);
    check({tag, "_load_done"},  load_done,   0);
    check({tag, "_load_error"}, load_error,  0);
  endtask

  task automatic set_frame1();
    pay.delete();
    pay.push_back(32'h1234_5678);
    pay.push_back(32'hDEAD_BEEF);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int base;
    reset      = 1'b0;
    load_start = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    for (int i = 0; i < DEPTH; i++) mem_img[i] = 32'h0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset  = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clock);

    // Normal load: 02 00 00 00, 78 56 34 12, EF BE AD DE, 2A.
    set_frame1();
    check("model_checksum", frame_xor(), 8'h2A);
    base = n_writes;
    run_frame(32'd2, 1'b0, 1'b0, -1, -1);
    check("normal_writes", n_writes - base, 2);
    check("normal_word0", mem_img[0], 32'h1234_5678);
    check("normal_word1", mem_img[1], 32'hDEAD_BEEF);
    check("normal_load_done", load_done, 1);
    check("normal_core_run", core_run, 1);

    // Empty load from DONE.
    pay.delete();
    base = n_writes;
    run_frame(32'd0, 1'b0, 1'b0, -1, -1);
    check("empty_writes", n_writes - base, 0);
    check("empty_core_run", core_run, 1);

    // Oversize: 01 10 00 00 (N = 4097).
    base = n_writes;
    run_frame(32'h0000_1001, 1'b0, 1'b0, -1, -1);
    check("oversize_writes", n_writes - base, 0);
    check("oversize_error", load_error, 1);
    check("oversize_core_run", core_run, 0);

    // Oversize only through the upper header bytes (low bits zero).
    base = n_writes;
    run_frame(32'h0001_0000, 1'b0, 1'b0, -1, -1);
    check("upper_byte_writes", n_writes - base, 0);
    check("upper_byte_error", load_error, 1);

    // Bad checksum 2B: both words still written.
    set_frame1();
    mem_img[0] = 32'h0;
    mem_img[1] = 32'h0;
    base = n_writes;
    run_frame(32'd2, 1'b1, 1'b0, -1, -1);
    check("badsum_writes", n_writes - base, 2);
    check("badsum_word1", mem_img[1], 32'hDEAD_BEEF);
    check("badsum_error", load_error, 1);
    check("badsum_core_run", core_run, 0);

    // Random gaps, held bytes across WRITE, stray load_start mid-payload.
    mem_img[0] = 32'h0;
    mem_img[1] = 32'h0;
    base = n_writes;
    run_frame(32'd2, 1'b0, 1'b1, -1, 6);
    check("gaps_writes", n_writes - base, 2);
    check("gaps_word0", mem_img[0], 32'h1234_5678);
    check("gaps_word1", mem_img[1], 32'hDEAD_BEEF);
    check("gaps_load_done", load_done, 1);

    // N == DEPTH: last write at DEPTH-1, no wrap.
    pay.delete();
    for (int i = 0; i < DEPTH; i++) pay.push_back(32'hA500_0000 ^ (i * 32'h0001_0001));
    base = n_writes;
    run_frame(32'd4096, 1'b0, 1'b0, -1, -1);
    check("full_writes", n_writes - base, DEPTH);
    check("full_first", mem_img[0], 32'hA500_0000);
    check("full_last", mem_img[DEPTH-1], 32'hAAFF_0FFF);
    check("full_load_done", load_done, 1);

    // Reset after 5 payload bytes, then a complete reload.
    set_frame1();
    run_frame(32'd2, 1'b0, 1'b0, 9, -1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    exp_error = 1'b0;
    write_due = 1'b0;
    exp_wq.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    base = n_writes;
    run_frame(32'd2, 1'b0, 1'b0, -1, -1);
    check("reload_writes", n_writes - base, 2);
    check("reload_word0", mem_img[0], 32'h1234_5678);
    check("reload_word1", mem_img[1], 32'hDEAD_BEEF);
    check("reload_core_run", core_run, 1);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
